ritc_pattern_player: RTL and testbench



---
 rtl/ritc_player_pkg.sv | 11 +
 rtl/ritc_pattern_ram.sv | 25 ++
 rtl/ritc_pattern_player.sv | 114 +++++++++++
 tb/tb_ritc_pattern_player.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ritc_player_pkg.sv
// ritc_player_pkg: shared state encoding, register map and CTRL field positions for the pattern player
package ritc_player_pkg;
   typedef enum logic [1:0] {IDLE, ARM, PLAY, DONE} state_t;
   localparam logic [10:0] CTRL_ADDR = 11'h400;
   localparam logic [10:0] PTR_ADDR = 11'h401;
   localparam int START_BIT = 0;
   localparam int LOOP_BIT = 1;
   localparam int STOP_BIT = 2;
   localparam int LAST_LSB = 16;
   localparam int HALF_WIDTH_DEF = 24;
endpackage

// File: rtl/ritc_pattern_ram.sv
// ritc_pattern_ram: pattern store as two independently written halves, one write port, one combinational read port
module ritc_pattern_ram
   import ritc_player_pkg::*;
#(
   parameter int ADDR_BITS = 9,
   parameter int HALF_WIDTH = HALF_WIDTH_DEF
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic                    hi,
   input  logic [ADDR_BITS-1:0]    waddr,
   input  logic [HALF_WIDTH-1:0]   wdata,
   input  logic [ADDR_BITS-1:0]    raddr,
   output logic [2*HALF_WIDTH-1:0] rdata
);
   logic [HALF_WIDTH-1:0] lo_mem [2**ADDR_BITS];
   logic [HALF_WIDTH-1:0] hi_mem [2**ADDR_BITS];
   // low half write lane
   always_ff @(posedge clk)
      if (we && !hi) lo_mem[waddr] <= wdata;
   // high half write lane
   always_ff @(posedge clk)
      if (we && hi) hi_mem[waddr] <= wdata;
   assign rdata = {hi_mem[raddr], lo_mem[raddr]};
endmodule

// File: rtl/ritc_pattern_player.sv
// ritc_pattern_player: replays a bus-loaded 48-bit pattern aligned to sync_i; PATTERN_READBACK_EN enables memory readback
module ritc_pattern_player
   import ritc_player_pkg::*;
#(
   parameter int ADDR_BITS = 9,
   parameter int HALF_WIDTH = HALF_WIDTH_DEF
) (
   input  logic                    sysclk_i,
   input  logic                    rst_i,
   input  logic                    sync_i,
   input  logic                    user_sel_i,
   input  logic                    user_wr_i,
   input  logic                    user_rd_i,
   input  logic [10:0]             user_addr_i,
   input  logic [31:0]             user_dat_i,
   output logic [31:0]             user_dat_o,
   output logic [2*HALF_WIDTH-1:0] dat_o,
   output logic                    valid_o,
   output logic                    busy_o,
   output logic                    done_o
);
   state_t state, state_d;
   logic [ADDR_BITS-1:0] ptr, last, last_sh, raddr;
   logic loop, loop_sh;
   logic [2*HALF_WIDTH-1:0] rdata;
   logic [31:0] mem_rd, rd_val;
   logic ctrl_wr, start, stop, mem_we, at_last, play;
   logic unused;

   assign ctrl_wr = user_sel_i && user_wr_i && user_addr_i == CTRL_ADDR;
   assign start = ctrl_wr && user_dat_i[START_BIT] && !user_dat_i[STOP_BIT];
   assign stop = ctrl_wr && user_dat_i[STOP_BIT];
   assign busy_o = state == ARM || state == PLAY;
   assign done_o = state == DONE;
   assign mem_we = user_sel_i && user_wr_i && !user_addr_i[10] && !busy_o;
   assign at_last = ptr == last_sh;
   assign play = state == PLAY && !stop;
   assign unused = ^user_dat_i[31:25];

`ifdef PATTERN_READBACK_EN
   assign raddr = busy_o ? ptr : user_addr_i[ADDR_BITS:1];
   assign mem_rd = (!user_addr_i[10] && !busy_o) ?
                   32'(user_addr_i[0] ? rdata[2*HALF_WIDTH-1:HALF_WIDTH] : rdata[HALF_WIDTH-1:0]) : '0;
`else
   assign raddr = ptr;
   assign mem_rd = '0;
`endif

   assign rd_val = (user_addr_i == CTRL_ADDR) ? 32'({last, 13'b0, done_o, loop, busy_o}) :
                   (user_addr_i == PTR_ADDR) ? 32'(ptr) : mem_rd;

   ritc_pattern_ram #(.ADDR_BITS(ADDR_BITS), .HALF_WIDTH(HALF_WIDTH)) u_ram (
      .clk   (sysclk_i),
      .we    (mem_we),
      .hi    (user_addr_i[0]),
      .waddr (user_addr_i[ADDR_BITS:1]),
      .wdata (user_dat_i[HALF_WIDTH-1:0]),
      .raddr (raddr),
      .rdata (rdata)
   );

   // state register
   always_ff @(posedge sysclk_i or posedge rst_i)
      if (rst_i) state <= IDLE;
      else state <= state_d;

   // next state: START only honoured when idle or done, STOP wins while busy
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    state_d = start ? ARM : IDLE;
         ARM:     state_d = stop ? IDLE : sync_i ? PLAY : ARM;
         PLAY:    state_d = stop ? IDLE : (at_last && !loop_sh) ? DONE : PLAY;
         DONE:    state_d = start ? ARM : DONE;
         default: state_d = IDLE;
      endcase
   end

   // CTRL fields, their per-run shadows and the playback pointer
   always_ff @(posedge sysclk_i or posedge rst_i)
      if (rst_i) begin
         last <= '0;
         loop <= 1'b0;
         last_sh <= '0;
         loop_sh <= 1'b0;
         ptr <= '0;
      end else begin
         if (ctrl_wr) begin
            last <= user_dat_i[LAST_LSB +: ADDR_BITS];
            loop <= user_dat_i[LOOP_BIT];
         end
         if (start && !busy_o) begin
            last_sh <= user_dat_i[LAST_LSB +: ADDR_BITS];
            loop_sh <= user_dat_i[LOOP_BIT];
         end
         if (state == ARM) ptr <= '0;
         else if (state == PLAY) ptr <= at_last ? '0 : ptr + 1'b1;
      end

   // playback output register, zero whenever not carrying pattern data
   always_ff @(posedge sysclk_i or posedge rst_i)
      if (rst_i) begin
         valid_o <= 1'b0;
         dat_o <= '0;
      end else begin
         valid_o <= play;
         dat_o <= play ? rdata : '0;
      end

   // registered bus read data, held between reads
   always_ff @(posedge sysclk_i or posedge rst_i)
      if (rst_i) user_dat_o <= '0;
      else if (user_sel_i && user_rd_i) user_dat_o <= rd_val;
endmodule

// File: tb/tb_ritc_pattern_player.sv
// tb_ritc_pattern_player: directed plus randomized checks of the pattern player against a word-array model
module tb_ritc_pattern_player;
   localparam logic [10:0] CTRL = 11'h400;
   localparam logic [10:0] PTR = 11'h401;

   logic sysclk_i = 1'b0;
   logic rst_i = 1'b1;
   logic sync_i = 1'b0;
   logic user_sel_i = 1'b0;
   logic user_wr_i = 1'b0;
   logic user_rd_i = 1'b0;
   logic [10:0] user_addr_i = '0;
   logic [31:0] user_dat_i = '0;
   logic [31:0] user_dat_o;
   logic [47:0] dat_o;
   logic valid_o, busy_o, done_o;

   logic [47:0] model_mem [16];
   int n_vec = 0;
   int n_err = 0;

   ritc_pattern_player dut (
      .sysclk_i    (sysclk_i),
      .rst_i       (rst_i),
      .sync_i      (sync_i),
      .user_sel_i  (user_sel_i),
      .user_wr_i   (user_wr_i),
      .user_rd_i   (user_rd_i),
      .user_addr_i (user_addr_i),
      .user_dat_i  (user_dat_i),
      .user_dat_o  (user_dat_o),
      .dat_o       (dat_o),
      .valid_o     (valid_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 sysclk_i = ~sysclk_i;

   task automatic tick();
      @(posedge sysclk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ctrl(input int lst, input bit lp, input bit st, input bit sp);
      logic [8:0] l9;
      l9 = 9'(lst);
      return {7'b0, l9, 13'b0, sp, lp, st};
   endfunction

   task automatic bus_write(input logic [10:0] a, input logic [31:0] d);
      user_sel_i = 1'b1;
      user_wr_i = 1'b1;
      user_addr_i = a;
      user_dat_i = d;
      tick();
      user_sel_i = 1'b0;
      user_wr_i = 1'b0;
   endtask

   task automatic bus_read(input logic [10:0] a, output logic [31:0] d);
      user_sel_i = 1'b1;
      user_rd_i = 1'b1;
      user_addr_i = a;
      tick();
      user_sel_i = 1'b0;
      user_rd_i = 1'b0;
      d = user_dat_o;
   endtask

   task automatic load(input int w, input logic [47:0] v);
      bus_write(11'(2 * w), {8'b0, v[23:0]});
      bus_write(11'(2 * w + 1), {8'b0, v[47:24]});
      model_mem[w] = v;
   endtask

   // from ARM: random wait, sync pulse, then the expected word stream
   task automatic play(input int nlast, input int nchk, input bit lp);
      int w;
      w = $urandom_range(0, 4);
      repeat (w) begin
         chk("arm_busy", 48'(busy_o), 48'd1);
         chk("arm_valid", 48'(valid_o), 48'd0);
         tick();
      end
      sync_i = 1'b1;
      tick();
      sync_i = 1'b0;
      chk("sync_valid", 48'(valid_o), 48'd0);
      tick();
      for (int i = 0; i < nchk; i++) begin
         chk("play_valid", 48'(valid_o), 48'd1);
         chk("play_dat", dat_o, model_mem[i % (nlast + 1)]);
         tick();
      end
      if (!lp) begin
         chk("end_valid", 48'(valid_o), 48'd0);
         chk("end_dat", dat_o, 48'd0);
         chk("end_done", 48'(done_o), 48'd1);
         chk("end_busy", 48'(busy_o), 48'd0);
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic [23:0] lo, hi;
      int nl;
      tick();
      chk("rst_dat", dat_o, 48'd0);
      chk("rst_valid", 48'(valid_o), 48'd0);
      chk("rst_busy", 48'(busy_o), 48'd0);
      chk("rst_done", 48'(done_o), 48'd0);
      chk("rst_user_dat", 48'(user_dat_o), 48'd0);
      rst_i = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) load(i, {24'(2 * i + 1), 24'(2 * i + 2)});
      for (int i = 4; i < 16; i++) load(i, {24'($urandom), 24'($urandom)});
      // single non-looping run
      bus_write(CTRL, ctrl(3, 0, 1, 0));
      bus_read(CTRL, rd);
      chk("status_arm", 48'(rd), 48'h0003_0001);
      play(3, 4, 0);
      bus_read(CTRL, rd);
      chk("status_done", 48'(rd), 48'h0003_0004);
      tick();
      chk("rd_hold", 48'(user_dat_o), 48'h0003_0004);
      // looping run then STOP
      bus_write(CTRL, ctrl(3, 1, 1, 0));
      play(3, 10, 1);
      bus_write(CTRL, ctrl(0, 0, 0, 1));
      chk("stop_valid", 48'(valid_o), 48'd0);
      chk("stop_dat", dat_o, 48'd0);
      chk("stop_busy", 48'(busy_o), 48'd0);
      chk("stop_done", 48'(done_o), 48'd0);
      bus_read(CTRL, rd);
      chk("status_stop", 48'(rd), 48'd0);
      bus_write(CTRL, ctrl(2, 0, 1, 1));
      chk("start_stop_busy", 48'(busy_o), 48'd0);
      // long wait for sync with a random length
      nl = $urandom_range(4, 15);
      bus_write(CTRL, ctrl(nl, 0, 1, 0));
      repeat (20) begin
         chk("wait_busy", 48'(busy_o), 48'd1);
         chk("wait_valid", 48'(valid_o), 48'd0);
         tick();
      end
      play(nl, nl + 1, 0);
      // writes during PLAY must not disturb the running pass
      bus_write(CTRL, ctrl(3, 0, 1, 0));
      sync_i = 1'b1;
      tick();
      sync_i = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("busy_play_valid", 48'(valid_o), 48'd1);
         chk("busy_play_dat", dat_o, model_mem[i]);
         if (i == 0) begin
            user_sel_i = 1'b1; user_wr_i = 1'b1; user_addr_i = 11'h002; user_dat_i = 32'h00AB_CDEF;
         end else if (i == 1) begin
            user_sel_i = 1'b1; user_wr_i = 1'b1; user_addr_i = CTRL; user_dat_i = ctrl(0, 0, 0, 0);
         end
         tick();
         user_sel_i = 1'b0;
         user_wr_i = 1'b0;
      end
      chk("busy_play_end", 48'(valid_o), 48'd0);
      chk("busy_play_done", 48'(done_o), 48'd1);
      bus_read(CTRL, rd);
      chk("status_shadow", 48'(rd), 48'h0000_0004);
      bus_write(CTRL, ctrl(0, 0, 1, 0));
      play(0, 1, 0);
      bus_write(CTRL, ctrl(1, 0, 1, 0));
      play(1, 2, 0);
      // asynchronous reset in the middle of playback
      bus_write(CTRL, ctrl(15, 1, 1, 0));
      sync_i = 1'b1;
      tick();
      sync_i = 1'b0;
      repeat (3) tick();
      chk("pre_rst_valid", 48'(valid_o), 48'd1);
      #3 rst_i = 1'b1;
      #1;
      chk("arst_valid", 48'(valid_o), 48'd0);
      chk("arst_dat", dat_o, 48'd0);
      chk("arst_busy", 48'(busy_o), 48'd0);
      @(negedge sysclk_i);
      rst_i = 1'b0;
      tick();
      bus_read(CTRL, rd);
      chk("status_after_rst", 48'(rd), 48'd0);
      bus_read(PTR, rd);
      chk("ptr_after_rst", 48'(rd), 48'd0);
      bus_read(11'h402, rd);
      chk("unmapped_rd", 48'(rd), 48'd0);
      // memory-space reads
      lo = 24'($urandom);
      hi = 24'($urandom);
      load(5, {hi, lo});
      bus_read(11'h00A, rd);
`ifdef PATTERN_READBACK_EN
      chk("readback_lo", 48'(rd), 48'(lo));
`else
      chk("readback_lo", 48'(rd), 48'd0);
`endif
      bus_read(11'h00B, rd);
`ifdef PATTERN_READBACK_EN
      chk("readback_hi", 48'(rd), 48'(hi));
`else
      chk("readback_hi", 48'(rd), 48'd0);
`endif
      bus_write(CTRL, ctrl(5, 0, 1, 0));
      play(5, 6, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
